dual_port_ram_pipe: RTL and testbench

Parametrised single-clock true dual-port RAM with independent, configurable write and read latency pipelines per port, a write-collision arbiter and read-valid strobes. It supersedes the dual-clock latency-RAM pair (a separate latency stage feeding a plain memory) by folding the delay lines into the memory block itself. It sits directly behind the banking controller as one bank instance.

---
 rtl/dual_port_ram_pipe.sv | 153 +++++++++++++++
 tb/tb_dual_port_ram_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_pipe.sv
// dual_port_ram_pipe: single-clock true dual-port RAM with per-port write/read latency pipelines
//
// Ports:
//   clk, rst                   single clock (posedge), asynchronous active-high reset
//   i_en_x / i_we_x            port request enable, 1 = write / 0 = read
//   i_addr_x / i_din_x         request address and write data
//   o_dout_x / o_valid_x       read data (held between reads) and its one-cycle valid strobe
//   o_wr_coll                  both ports committed to the same address on the previous edge
// Optional feature macro DPRAM_PARITY_EN adds one even-parity bit per word plus
//   i_perr_inj_x (invert stored parity on write) and o_perr_x (parity failure, aligned with o_valid_x).
module dual_port_ram_pipe #(
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_DEPTH   = 16,
    parameter int ADDR_WIDTH  = $clog2(MEM_DEPTH),
    parameter int WR_LATENCYA = 1,
    parameter int RD_LATENCYA = 1,
    parameter int WR_LATENCYB = 1,
    parameter int RD_LATENCYB = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en_a,
    input  logic                  i_en_b,
    input  logic                  i_we_a,
    input  logic                  i_we_b,
    input  logic [ADDR_WIDTH-1:0] i_addr_a,
    input  logic [ADDR_WIDTH-1:0] i_addr_b,
    input  logic [DATA_WIDTH-1:0] i_din_a,
    input  logic [DATA_WIDTH-1:0] i_din_b,
    output logic [DATA_WIDTH-1:0] o_dout_a,
    output logic [DATA_WIDTH-1:0] o_dout_b,
    output logic                  o_valid_a,
    output logic                  o_valid_b,
    output logic                  o_wr_coll
`ifdef DPRAM_PARITY_EN
    ,
    input  logic                  i_perr_inj_a,
    input  logic                  i_perr_inj_b,
    output logic                  o_perr_a,
    output logic                  o_perr_b
`endif
);
`ifdef DPRAM_PARITY_EN
    localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
    localparam int MEM_WIDTH = DATA_WIDTH;
`endif

    logic [1:0]            en, we, cv, rv;
    logic [ADDR_WIDTH-1:0] addr [2];
    logic [ADDR_WIDTH-1:0] ca [2];
    logic [MEM_WIDTH-1:0]  wword [2];
    logic [MEM_WIDTH-1:0]  cd [2];
    logic [MEM_WIDTH-1:0]  rword [2];
    logic [MEM_WIDTH-1:0]  mem [MEM_DEPTH];
    logic                  ok_a, ok_b, coll_d, wr_coll_q;

    assign en      = {i_en_b, i_en_a};
    assign we      = {i_we_b, i_we_a};
    assign addr[0] = i_addr_a;
    assign addr[1] = i_addr_b;
`ifdef DPRAM_PARITY_EN
    // Even parity: stored bit makes the whole word XOR to 0 unless injection flips it.
    assign wword[0] = {^i_din_a ^ i_perr_inj_a, i_din_a};
    assign wword[1] = {^i_din_b ^ i_perr_inj_b, i_din_b};
`else
    assign wword[0] = i_din_a;
    assign wword[1] = i_din_b;
`endif

    for (genvar p = 0; p < 2; p++) begin : g_port
        localparam int WL = (p == 0) ? WR_LATENCYA : WR_LATENCYB;
        localparam int RL = (p == 0) ? RD_LATENCYA : RD_LATENCYB;
        logic                 rv_q [RL];
        logic [MEM_WIDTH-1:0] rd_q [RL];
        logic [MEM_WIDTH-1:0] rd_d;
        assign rd_d = (int'(addr[p]) < MEM_DEPTH) ? mem[addr[p]] : '0;
        // Each stage only loads data alongside a valid, so the last stage holds the previous result.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < RL; k++) begin
                    rv_q[k] <= 1'b0;
                    rd_q[k] <= '0;
                end
            end else begin
                rv_q[0] <= en[p] & ~we[p];
                if (en[p] && !we[p]) rd_q[0] <= rd_d;
                for (int k = 1; k < RL; k++) begin
                    rv_q[k] <= rv_q[k-1];
                    if (rv_q[k-1]) rd_q[k] <= rd_q[k-1];
                end
            end
        end
        assign rv[p]    = rv_q[RL-1];
        assign rword[p] = rd_q[RL-1];
        if (WL > 1) begin : g_wpipe
            logic                  wv_q [WL-1];
            logic [ADDR_WIDTH-1:0] wa_q [WL-1];
            logic [MEM_WIDTH-1:0]  wd_q [WL-1];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < WL - 1; k++) begin
                        wv_q[k] <= 1'b0;
                        wa_q[k] <= '0;
                        wd_q[k] <= '0;
                    end
                end else begin
                    wv_q[0] <= en[p] & we[p];
                    wa_q[0] <= addr[p];
                    wd_q[0] <= wword[p];
                    for (int k = 1; k < WL - 1; k++) begin
                        wv_q[k] <= wv_q[k-1];
                        wa_q[k] <= wa_q[k-1];
                        wd_q[k] <= wd_q[k-1];
                    end
                end
            end
            assign cv[p] = wv_q[WL-2];
            assign ca[p] = wa_q[WL-2];
            assign cd[p] = wd_q[WL-2];
        end else begin : g_wbyp
            // Single-cycle write latency commits straight from the request inputs.
            assign cv[p] = en[p] & we[p];
            assign ca[p] = addr[p];
            assign cd[p] = wword[p];
        end
    end

    assign ok_a   = cv[0] && (int'(ca[0]) < MEM_DEPTH);
    assign ok_b   = cv[1] && (int'(ca[1]) < MEM_DEPTH);
    assign coll_d = ok_a && ok_b && (ca[0] == ca[1]);

    // Array is never reset; commits are suppressed while rst is high so in-flight writes die.
    always_ff @(posedge clk) begin
        if (!rst && ok_b && !coll_d) mem[ca[1]] <= cd[1];
        if (!rst && ok_a) mem[ca[0]] <= cd[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_coll_q <= 1'b0;
        else wr_coll_q <= coll_d;
    end

    assign o_dout_a  = rword[0][DATA_WIDTH-1:0];
    assign o_dout_b  = rword[1][DATA_WIDTH-1:0];
    assign o_valid_a = rv[0];
    assign o_valid_b = rv[1];
    assign o_wr_coll = wr_coll_q;
`ifdef DPRAM_PARITY_EN
    assign o_perr_a = rv[0] & (^rword[0]);
    assign o_perr_b = rv[1] & (^rword[1]);
`endif
endmodule

// File: tb/tb_dual_port_ram_pipe.sv
// tb_dual_port_ram_pipe: directed and randomized bench with a queue-based reference model
module tb_dual_port_ram_pipe;
    localparam int DEPTH = 12;
    localparam int WLA = 3, RLA = 2, WLB = 1, RLB = 3;

    typedef struct {int due; int port; int addr; logic [7:0] data; bit bad;} ev_t;

    logic clk = 0, rst = 0;
    logic en_a = 0, en_b = 0, we_a = 0, we_b = 0, inj_a = 0, inj_b = 0;
    logic [3:0] addr_a = 0, addr_b = 0;
    logic [7:0] din_a = 0, din_b = 0;
    logic [7:0] o_dout_a, o_dout_b;
    logic o_valid_a, o_valid_b, o_wr_coll;
`ifdef DPRAM_PARITY_EN
    logic o_perr_a, o_perr_b;
`endif

    int checks = 0, errors = 0, cyc = 0;
    ev_t wq[$], rq[$];
    logic [7:0] mem_m [16];
    bit bad_m [16];
    logic [7:0] exp_dout [2];
    bit exp_valid [2], exp_perr [2], exp_coll;
    logic [7:0] sd [16];

    dual_port_ram_pipe #(
        .DATA_WIDTH(8), .MEM_DEPTH(DEPTH),
        .WR_LATENCYA(WLA), .RD_LATENCYA(RLA), .WR_LATENCYB(WLB), .RD_LATENCYB(RLB)
    ) dut (
        .clk(clk), .rst(rst),
        .i_en_a(en_a), .i_en_b(en_b), .i_we_a(we_a), .i_we_b(we_b),
        .i_addr_a(addr_a), .i_addr_b(addr_b), .i_din_a(din_a), .i_din_b(din_b),
        .o_dout_a(o_dout_a), .o_dout_b(o_dout_b),
        .o_valid_a(o_valid_a), .o_valid_b(o_valid_b), .o_wr_coll(o_wr_coll)
`ifdef DPRAM_PARITY_EN
        , .i_perr_inj_a(inj_a), .i_perr_inj_b(inj_b), .o_perr_a(o_perr_a), .o_perr_b(o_perr_b)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One clock: log this cycle's requests, take the edge, then retire everything due at it.
    task automatic tick();
        logic pe [2], pw [2], pi [2];
        int pa [2];
        logic [7:0] pd [2];
        ev_t e;
        ev_t nq[$];
        bit cv [2], cb [2];
        int ca [2];
        logic [7:0] cd [2];
        if (!rst) begin
            pe = '{en_a, en_b}; pw = '{we_a, we_b}; pi = '{inj_a, inj_b};
            pa = '{int'(addr_a), int'(addr_b)}; pd = '{din_a, din_b};
            for (int p = 0; p < 2; p++) if (pe[p]) begin
                e.port = p; e.addr = pa[p];
                if (pw[p]) begin
                    e.due = cyc + (p ? WLB : WLA); e.data = pd[p]; e.bad = pi[p];
                    wq.push_back(e);
                end else begin
                    // Sampled before this edge's commits: reads see the old word.
                    e.due = cyc + (p ? RLB : RLA);
                    e.data = (pa[p] < DEPTH) ? mem_m[pa[p]] : 8'h00;
                    e.bad = (pa[p] < DEPTH) && bad_m[pa[p]];
                    rq.push_back(e);
                end
            end
        end
        @(posedge clk);
        cyc++;
        exp_valid = '{0, 0}; exp_perr = '{0, 0}; exp_coll = 0;
        if (rst) begin
            wq.delete(); rq.delete(); exp_dout = '{8'h00, 8'h00};
        end else begin
            cv = '{0, 0}; ca = '{0, 0}; cd = '{8'h00, 8'h00}; cb = '{0, 0};
            foreach (wq[i]) if (wq[i].due == cyc) begin
                cv[wq[i].port] = 1; ca[wq[i].port] = wq[i].addr;
                cd[wq[i].port] = wq[i].data; cb[wq[i].port] = wq[i].bad;
            end else nq.push_back(wq[i]);
            wq = nq;
            exp_coll = cv[0] && cv[1] && ca[0] < DEPTH && ca[0] == ca[1];
            if (cv[1] && ca[1] < DEPTH && !exp_coll) begin mem_m[ca[1]] = cd[1]; bad_m[ca[1]] = cb[1]; end
            if (cv[0] && ca[0] < DEPTH) begin mem_m[ca[0]] = cd[0]; bad_m[ca[0]] = cb[0]; end
            nq = {};
            foreach (rq[i]) if (rq[i].due == cyc) begin
                exp_valid[rq[i].port] = 1; exp_dout[rq[i].port] = rq[i].data; exp_perr[rq[i].port] = rq[i].bad;
            end else nq.push_back(rq[i]);
            rq = nq;
        end
        #1;
    endtask

    task automatic drive(input int p, input bit en, input bit we, input int a, input logic [7:0] d, input bit inj);
        if (p == 0) begin en_a = en; we_a = we; addr_a = 4'(a); din_a = d; inj_a = inj; end
        else begin en_b = en; we_b = we; addr_b = 4'(a); din_b = d; inj_b = inj; end
    endtask

    task automatic clear();
        drive(0, 0, 0, 0, 8'h00, 0);
        drive(1, 0, 0, 0, 8'h00, 0);
    endtask

    task automatic idle(input int n);
        clear();
        repeat (n) tick();
    endtask

    task automatic do_read(input int p, input int a, output logic [7:0] d, output bit got);
        got = 0; d = 8'h00;
        drive(p, 1, 0, a, 8'h00, 0);
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            clear();
            if ((p ? o_valid_b : o_valid_a) === 1'b1) begin got = 1; d = p ? o_dout_b : o_dout_a; end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1;
        #1;
        checks++;
        if ({o_valid_a, o_valid_b, o_wr_coll, o_dout_a, o_dout_b} !== 19'h0) begin
            errors++;
            $display("FAIL reset_async: got %b/%b/%b %h %h want all 0", o_valid_a, o_valid_b, o_wr_coll, o_dout_a, o_dout_b);
        end
        tick(); tick();
        checks++;
        if ({o_valid_a, o_valid_b, o_wr_coll, o_dout_a, o_dout_b} !== 19'h0) begin
            errors++;
            $display("FAIL reset_held: got %b/%b/%b %h %h want all 0", o_valid_a, o_valid_b, o_wr_coll, o_dout_a, o_dout_b);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_streaming();
        logic [7:0] got[$];
        int first = -1, last = -1;
        for (int a = 0; a < 16; a++) begin
            sd[a] = 8'($urandom_range(255));
            drive(1, 1, 1, a, sd[a], 0);
            tick();
        end
        for (int a = 0; a < 16; a++) begin
            if (a >= DEPTH) sd[a] = 8'h00;
            drive(1, 1, 0, a, 8'h00, 0);
            tick();
            if (o_valid_b) begin got.push_back(o_dout_b); if (first < 0) first = cyc; last = cyc; end
        end
        clear();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (o_valid_b) begin got.push_back(o_dout_b); if (first < 0) first = cyc; last = cyc; end
        end
        checks++;
        if (got.size() != 16 || last - first != 15) begin
            errors++;
            $display("FAIL stream_pulses: got %0d pulses over %0d cycles want 16 over 16", got.size(), last - first + 1);
        end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== sd[i]) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, got[i], sd[i]); end
        end
    endtask

    task automatic test_latency();
        idle(6);
        drive(0, 1, 1, 5, 8'hA5, 0); tick();
        clear(); tick();
        drive(0, 1, 0, 5, 8'h00, 0); tick();
        checks++;
        if (o_valid_a !== 1'b0) begin errors++; $display("FAIL lat_early_valid: got %b want 0", o_valid_a); end
        drive(0, 1, 0, 5, 8'h00, 0); tick();
        checks++;
        if (o_valid_a !== 1'b1 || o_dout_a !== sd[5]) begin
            errors++; $display("FAIL lat_old_word: got v=%b d=%h want v=1 d=%h", o_valid_a, o_dout_a, sd[5]);
        end
        clear(); tick();
        checks++;
        if (o_valid_a !== 1'b1 || o_dout_a !== 8'hA5) begin
            errors++; $display("FAIL lat_new_word: got v=%b d=%h want v=1 d=a5", o_valid_a, o_dout_a);
        end
        tick();
        checks++;
        if (o_valid_a !== 1'b0 || o_dout_a !== 8'hA5) begin
            errors++; $display("FAIL lat_hold: got v=%b d=%h want v=0 d=a5", o_valid_a, o_dout_a);
        end
    endtask

    task automatic test_collision();
        logic [7:0] d;
        bit got;
        bit want;
        idle(6);
        // Port A takes two extra cycles to commit, so B issued two cycles later lands on the same edge.
        drive(0, 1, 1, 7, 8'h11, 0); tick();
        clear();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) drive(1, 1, 1, 7, 8'h22, 0);
            tick();
            clear();
            want = (i == 1);
            checks++;
            if (o_wr_coll !== want) begin errors++; $display("FAIL coll_strobe[%0d]: got %b want %b", i, o_wr_coll, want); end
        end
        do_read(1, 7, d, got);
        checks++;
        if (!got || d !== 8'h11) begin errors++; $display("FAIL coll_winner: got v=%b d=%h want v=1 d=11", got, d); end
        idle(4);
        drive(0, 1, 1, 7, 8'h33, 0); drive(1, 1, 1, 7, 8'h44, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            clear();
            checks++;
            if (o_wr_coll !== 1'b0) begin errors++; $display("FAIL coll_skew[%0d]: got %b want 0", i, o_wr_coll); end
        end
        do_read(1, 7, d, got);
        checks++;
        if (!got || d !== 8'h33) begin errors++; $display("FAIL coll_skew_final: got v=%b d=%h want v=1 d=33", got, d); end
    endtask

    task automatic test_read_first();
        logic [7:0] got[$];
        idle(6);
        drive(1, 1, 1, 2, 8'hC3, 0); tick();
        clear(); tick();
        drive(1, 1, 1, 2, 8'h3C, 0); drive(0, 1, 0, 2, 8'h00, 0); tick();
        if (o_valid_a) got.push_back(o_dout_a);
        clear(); drive(0, 1, 0, 2, 8'h00, 0); tick();
        if (o_valid_a) got.push_back(o_dout_a);
        clear();
        for (int i = 0; i < 6; i++) begin tick(); if (o_valid_a) got.push_back(o_dout_a); end
        checks++;
        if (got.size() != 2) begin errors++; $display("FAIL rf_count: got %0d reads want 2", got.size()); end
        else begin
            checks++;
            if (got[0] !== 8'hC3) begin errors++; $display("FAIL rf_old: got %h want c3", got[0]); end
            checks++;
            if (got[1] !== 8'h3C) begin errors++; $display("FAIL rf_new: got %h want 3c", got[1]); end
        end
    endtask

    task automatic test_reset_midflight();
        logic [7:0] d;
        bit got;
        int pulses = 0;
        idle(6);
        drive(1, 1, 1, 1, 8'h5A, 0); tick();
        idle(2);
        drive(0, 1, 1, 1, 8'hFF, 0); tick();
        drive(0, 1, 0, 4, 8'h00, 0); tick();
        clear();
        rst = 1;
        #1;
        checks++;
        if ({o_valid_a, o_valid_b, o_wr_coll, o_dout_a, o_dout_b} !== 19'h0) begin
            errors++;
            $display("FAIL midrst_async: got %b/%b/%b %h %h want all 0", o_valid_a, o_valid_b, o_wr_coll, o_dout_a, o_dout_b);
        end
        tick(); tick();
        checks++;
        if ({o_valid_a, o_valid_b, o_wr_coll, o_dout_a, o_dout_b} !== 19'h0) begin
            errors++;
            $display("FAIL midrst_held: got %b/%b/%b %h %h want all 0", o_valid_a, o_valid_b, o_wr_coll, o_dout_a, o_dout_b);
        end
        rst = 0;
        for (int i = 0; i < 6; i++) begin tick(); pulses += int'(o_valid_a); end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL midrst_dropped_read: got %0d pulses want 0", pulses); end
        do_read(0, 1, d, got);
        checks++;
        if (!got || d !== 8'h5A) begin errors++; $display("FAIL midrst_write_discarded: got v=%b d=%h want v=1 d=5a", got, d); end
    endtask

    task automatic test_random();
        idle(6);
        for (int n = 0; n < 420; n++) begin
            if (n < 400) begin
                drive(0, $urandom_range(3) != 0, $urandom_range(1), $urandom_range(15), 8'($urandom_range(255)), $urandom_range(7) == 0);
                drive(1, $urandom_range(3) != 0, $urandom_range(1), $urandom_range(15), 8'($urandom_range(255)), $urandom_range(7) == 0);
                // Bias toward shared addresses to provoke collisions and read/write overlap.
                if ($urandom_range(3) == 0) addr_b = addr_a;
            end else clear();
            tick();
            checks++;
            if (o_valid_a !== exp_valid[0]) begin errors++; $display("FAIL rand_valid_a @%0d: got %b want %b", cyc, o_valid_a, exp_valid[0]); end
            checks++;
            if (o_valid_b !== exp_valid[1]) begin errors++; $display("FAIL rand_valid_b @%0d: got %b want %b", cyc, o_valid_b, exp_valid[1]); end
            checks++;
            if (o_dout_a !== exp_dout[0]) begin errors++; $display("FAIL rand_dout_a @%0d: got %h want %h", cyc, o_dout_a, exp_dout[0]); end
            checks++;
            if (o_dout_b !== exp_dout[1]) begin errors++; $display("FAIL rand_dout_b @%0d: got %h want %h", cyc, o_dout_b, exp_dout[1]); end
            checks++;
            if (o_wr_coll !== exp_coll) begin errors++; $display("FAIL rand_coll @%0d: got %b want %b", cyc, o_wr_coll, exp_coll); end
`ifdef DPRAM_PARITY_EN
            checks++;
            if (o_perr_a !== exp_perr[0] || o_perr_b !== exp_perr[1]) begin
                errors++; $display("FAIL rand_perr @%0d: got %b%b want %b%b", cyc, o_perr_a, o_perr_b, exp_perr[0], exp_perr[1]);
            end
`endif
        end
    endtask

`ifdef DPRAM_PARITY_EN
    task automatic test_parity();
        logic [7:0] d;
        bit got;
        idle(6);
        drive(0, 1, 1, 3, 8'h0F, 1); tick();
        idle(4);
        do_read(0, 3, d, got);
        checks++;
        if (!got || d !== 8'h0F || o_perr_a !== 1'b1) begin
            errors++; $display("FAIL parity_inject: got v=%b d=%h perr=%b want v=1 d=0f perr=1", got, d, o_perr_a);
        end
        idle(2);
        drive(0, 1, 1, 3, 8'h0F, 0); tick();
        idle(4);
        do_read(0, 3, d, got);
        checks++;
        if (!got || d !== 8'h0F || o_perr_a !== 1'b0) begin
            errors++; $display("FAIL parity_clean: got v=%b d=%h perr=%b want v=1 d=0f perr=0", got, d, o_perr_a);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_latency();
        test_collision();
        test_read_first();
        test_reset_midflight();
        test_random();
`ifdef DPRAM_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
